// File: rtl/shift_frame_pkg.sv
// Shared types and default sizes for the shift frame receiver.
// PARITY_CHECK_EN adds the PARITY state.
package shift_frame_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int BIT_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_CHECK_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/shift_frame_receiver_if.sv
// Serial line and word-output bundle of the shift frame receiver.
// PARITY_CHECK_EN adds parity_err.
interface shift_frame_receiver_if
  import shift_frame_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              serial_in;
  logic              shift_dir;
  logic [DATA_W-1:0] signal_output;
  logic              data_valid;
  logic              frame_err;
  logic              busy;
`ifdef PARITY_CHECK_EN
  logic              parity_err;

  modport master (
    output serial_in, shift_dir,
    input  signal_output, data_valid,
    input  frame_err, busy, parity_err
  );

  modport slave (
    input  serial_in, shift_dir,
    output signal_output, data_valid,
    output frame_err, busy, parity_err
  );
`else
  modport master (
    output serial_in, shift_dir,
    input  signal_output, data_valid,
    input  frame_err, busy
  );

  modport slave (
    input  serial_in, shift_dir,
    output signal_output, data_valid,
    output frame_err, busy
  );
`endif

endinterface

// File: rtl/shift_frame_receiver_bit_timer.sv
// Bit-period counter; strobes once per bit at the mid-bit point.
// Held at zero while clr is high so the first strobe lands half a bit in.
module bit_timer
  import shift_frame_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic strobe
);

  localparam int TW = $clog2(BIT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] MID  = TW'(BIT_CYCLES / 2 - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign strobe = !clr && (cnt_q == MID);

endmodule

// File: rtl/shift_frame_receiver.sv
// Oversampled serial frame receiver: start, DATA_W bits, stop.
// PARITY_CHECK_EN adds an even-parity bit before stop.
module shift_frame_receiver
  import shift_frame_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input logic CLK,
  input logic RST,
  shift_frame_receiver_if.slave bus
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  state_t state_q, state_d;

  logic              si;
  logic              stb;
  logic              prev_q;
  logic              dir_q;
  logic [CW-1:0]     bit_q;
  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] out_q;
  logic              dv_q;
  logic              fe_q;

  logic arm;
  logic shift_en;
  logic good_stop;
  logic bad_stop;

`ifdef PARITY_CHECK_EN
  logic par_ld;
  logic perr_q;
  logic pe_q;
`endif

  assign si = bus.serial_in;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (state_q == IDLE),
    .strobe(stb)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arm       = 1'b0;
    shift_en  = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
`ifdef PARITY_CHECK_EN
    par_ld    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (prev_q && !si) begin
          state_d = START;
          arm     = 1'b1;
        end
      end
      START: begin
        if (stb) begin
          state_d = si ? IDLE : DATA;
        end
      end
      DATA: begin
        if (stb) begin
          shift_en = 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (stb) begin
          par_ld  = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (stb) begin
          good_stop = si;
          bad_stop  = !si;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= 1'b1;
      dir_q  <= 1'b0;
      bit_q  <= '0;
      sh_q   <= '0;
      out_q  <= '0;
      dv_q   <= 1'b0;
      fe_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q <= 1'b0;
      pe_q   <= 1'b0;
`endif
    end else begin
      prev_q <= si;
      dv_q   <= good_stop;
      fe_q   <= bad_stop;
      if (arm) begin
        dir_q <= bus.shift_dir;
        bit_q <= '0;
      end
      // dir_q picks which end the first wire bit ends up at
      if (shift_en) begin
        bit_q <= bit_q + 1'b1;
        sh_q  <= dir_q ? {sh_q[DATA_W-2:0], si}
                       : {si, sh_q[DATA_W-1:1]};
      end
      if (good_stop) begin
        out_q <= sh_q;
      end
`ifdef PARITY_CHECK_EN
      pe_q <= good_stop && perr_q;
      if (arm) begin
        perr_q <= 1'b0;
      end else if (par_ld) begin
        perr_q <= ^{sh_q, si};
      end
`endif
    end
  end

  assign bus.signal_output = out_q;
  assign bus.data_valid    = dv_q;
  assign bus.frame_err     = fe_q;
  assign bus.busy          = (state_q != IDLE);
`ifdef PARITY_CHECK_EN
  assign bus.parity_err    = pe_q;
`endif

endmodule

// File: tb/tb_shift_frame_receiver.sv
// Directed bench for shift_frame_receiver with a per-cycle timeline model.
// Honours PARITY_CHECK_EN when the design is built with it.
module tb_shift_frame_receiver;
  import shift_frame_pkg::*;

  localparam int W  = DATA_W_DEF;
  localparam int BC = BIT_CYCLES_DEF;
  localparam int H  = BC / 2;
  localparam int NC = 1024;
`ifdef PARITY_CHECK_EN
  localparam int PB     = 1;
  localparam int DV_OFS = 43;
`else
  localparam int PB     = 0;
  localparam int DV_OFS = 39;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;

  shift_frame_receiver_if #(.DATA_W(W)) bus ();

  shift_frame_receiver #(
    .DATA_W    (W),
    .BIT_CYCLES(BC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int cyc     = 0;
  int tests   = 0;
  int failed  = 0;
  bit check_en = 1'b0;

  bit         exp_busy [NC];
  bit         exp_dv   [NC];
  bit         exp_fe   [NC];
  bit         exp_pe   [NC];
  bit [W-1:0] exp_out  [NC];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit [W-1:0] word_of(bit [W-1:0] bits, bit dir);
    bit [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      if (dir) w[W-1-k] = bits[k];
      else     w[k]     = bits[k];
    end
    return w;
  endfunction

  function automatic void model_busy(int a, int b);
    for (int c = a; c <= b && c < NC; c++) exp_busy[c] = 1'b1;
  endfunction

  // Frame starting (line low) in cycle t0: stop sampled at ts, result at ts+1
  function automatic void model_frame(int t0, bit good, bit [W-1:0] w, bit perr);
    int ts;
    ts = t0 + H + (W + 1 + PB) * BC;
    model_busy(t0 + 1, ts);
    if (ts + 1 < NC) begin
      if (good) begin
        exp_dv[ts+1] = 1'b1;
        exp_pe[ts+1] = perr;
        for (int c = ts + 1; c < NC; c++) exp_out[c] = w;
      end else begin
        exp_fe[ts+1] = 1'b1;
      end
    end
  endfunction

  function automatic void model_reset(int r);
    for (int c = r + 1; c < NC; c++) begin
      exp_busy[c] = 1'b0;
      exp_dv[c]   = 1'b0;
      exp_fe[c]   = 1'b0;
      exp_pe[c]   = 1'b0;
      exp_out[c]  = '0;
    end
  endfunction

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (check_en && cyc < NC) begin
        check("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
        check("data_valid", 32'(bus.data_valid), 32'(exp_dv[cyc]));
        check("frame_err", 32'(bus.frame_err), 32'(exp_fe[cyc]));
        check("signal_output", 32'(bus.signal_output), 32'(exp_out[cyc]));
`ifdef PARITY_CHECK_EN
        check("parity_err", 32'(bus.parity_err), 32'(exp_pe[cyc]));
`endif
      end
    end
  end

  task automatic drive_bit(input bit v, input int n);
    @(negedge CLK);
    bus.serial_in = v;
    repeat (n - 1) @(negedge CLK);
  endtask

  // bits[k] is the k-th data bit on the wire; returns at the last stop cycle
  task automatic send_frame(input bit [W-1:0] bits, input bit dir,
                            input bit stop, input bit par,
                            input int stop_len, input int rst_at,
                            output int t0);
    bit abort;
    abort = 1'b0;
    @(negedge CLK);
    bus.serial_in = 1'b0;
    bus.shift_dir = dir;
    t0 = cyc;
    model_frame(t0, stop, word_of(bits, dir), ^{bits, par});
    repeat (BC - 1) @(negedge CLK);
    for (int k = 0; k < W && !abort; k++) begin
      if (k == rst_at) begin
        @(negedge CLK);
        bus.serial_in = bits[k];
        RST = 1'b1;
        model_reset(cyc);
        @(negedge CLK);
        RST = 1'b0;
        bus.serial_in = 1'b1;
        abort = 1'b1;
      end else begin
        drive_bit(bits[k], BC);
        if (k == 0) bus.shift_dir = !dir;
      end
    end
    if (!abort) begin
      if (PB == 1) drive_bit(par, BC);
      drive_bit(stop, stop_len);
    end
  endtask

  int t0, t1;

  initial begin
    bus.serial_in = 1'b1;
    bus.shift_dir = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check_en = 1'b1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out", 32'(bus.signal_output), 32'd0);
    check("rst_dv", 32'(bus.data_valid), 32'd0);

    // LSB-first 0x99
    send_frame(8'h99, 1'b0, 1'b1, ^8'h99, BC, -1, t0);
    check("pin_dv_cycle", 32'(exp_dv[t0+DV_OFS]), 32'd1);
    check("lsb_dv", 32'(bus.data_valid), 32'd1);
    check("lsb_out", 32'(bus.signal_output), 32'h99);
    repeat (3) @(negedge CLK);

    // back-to-back: short stop, then MSB-first 1,0,1,0,0,0,0,0
    send_frame(8'h5A, 1'b0, 1'b1, ^8'h5A, BC - 1, -1, t0);
    send_frame(8'h05, 1'b1, 1'b1, ^8'h05, BC, -1, t1);
    check("pin_msb_word", 32'(exp_out[t1+DV_OFS]), 32'hA0);
    check("msb_dv", 32'(bus.data_valid), 32'd1);
    check("msb_out", 32'(bus.signal_output), 32'hA0);
    repeat (3) @(negedge CLK);

    // one-cycle glitch
    @(negedge CLK);
    bus.serial_in = 1'b0;
    t0 = cyc;
    model_busy(t0 + 1, t0 + H);
    @(negedge CLK);
    bus.serial_in = 1'b1;
    @(negedge CLK);
    check("glitch_busy_t2", 32'(bus.busy), 32'd1);
    @(negedge CLK);
    check("glitch_busy_t3", 32'(bus.busy), 32'd0);
    check("glitch_out", 32'(bus.signal_output), 32'hA0);
    repeat (3) @(negedge CLK);

    // good 0x99, then 0x3C with a bad stop and the line held low
    send_frame(8'h99, 1'b0, 1'b1, ^8'h99, BC, -1, t0);
    send_frame(8'h3C, 1'b0, 1'b0, ^8'h3C, BC, -1, t0);
    check("ferr_pulse", 32'(bus.frame_err), 32'd1);
    check("ferr_dv", 32'(bus.data_valid), 32'd0);
    check("ferr_out", 32'(bus.signal_output), 32'h99);
    repeat (20) @(negedge CLK);
    check("ferr_no_retrig", 32'(bus.busy), 32'd0);
    bus.serial_in = 1'b1;
    repeat (4) @(negedge CLK);

    // reset during data bit 4, then 0x55
    send_frame(8'h3C, 1'b0, 1'b1, ^8'h3C, BC, 4, t0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_out", 32'(bus.signal_output), 32'd0);
    check("mid_rst_dv", 32'(bus.data_valid), 32'd0);
    check("mid_rst_fe", 32'(bus.frame_err), 32'd0);
    repeat (3) @(negedge CLK);
    send_frame(8'h55, 1'b0, 1'b1, ^8'h55, BC, -1, t0);
    check("post_rst_dv", 32'(bus.data_valid), 32'd1);
    check("post_rst_out", 32'(bus.signal_output), 32'h55);

`ifdef PARITY_CHECK_EN
    repeat (3) @(negedge CLK);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, BC, -1, t0);
    check("pin_perr", 32'(exp_pe[t0+DV_OFS]), 32'd1);
    check("par_dv", 32'(bus.data_valid), 32'd1);
    check("par_err", 32'(bus.parity_err), 32'd1);
    check("par_out", 32'(bus.signal_output), 32'h07);
`endif

    repeat (5) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/shift_frame_receiver.md
SHIFT_FRAME_RECEIVER -- requirements
Module: shift_frame_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame.
REQ-002 SHALL have parameter BIT_CYCLES, default 4, clocks per serial bit; even, >= 2.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port serial_in  input  1  serial line; idles high.
REQ-006 SHALL have port shift_dir  input  1  bit order: 0 = LSB-first, 1 = MSB-first.
REQ-007 SHALL have port signal_output  output  DATA_W  last correctly received word.
REQ-008 SHALL have port data_valid  output  1  one-cycle pulse when signal_output updates.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL use a state machine with states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-012 SHALL hold a registered copy prev of serial_in; start edge = prev==1 and serial_in==0 while in IDLE.
REQ-013 SHALL, on the start edge at cycle t0, latch shift_dir, clear the bit counter and enter START.
REQ-014 SHALL sample the start bit at t0+BIT_CYCLES/2; if 0, enter DATA; if 1 (glitch), return to IDLE with no pulse.
REQ-015 SHALL sample data bit k (k=0..DATA_W-1) at t0+BIT_CYCLES/2+(k+1)*BIT_CYCLES.
REQ-016 SHALL place the first data bit at bit 0 when the latched shift_dir is 0, and at bit DATA_W-1 when it is 1.
REQ-017 SHALL assemble the word in an internal shift register; signal_output SHALL NOT change mid-frame.
REQ-018 SHALL sample the stop bit one BIT_CYCLES after the last data bit, or after the parity bit when parity is enabled.
REQ-019 SHALL, when the stop bit is 1, load signal_output and pulse data_valid in the cycle after the stop sample, then return to IDLE.
REQ-020 SHALL, when the stop bit is 0, pulse frame_err in the cycle after the stop sample, keep signal_output unchanged and return to IDLE.
REQ-021 SHALL arm a new start only on a fresh high-to-low edge, so a line held low after a frame error cannot retrigger.
REQ-022 SHALL accept a start edge in the first IDLE cycle after STOP (back-to-back frames).
REQ-023 SHALL ignore shift_dir changes while busy.

Reset
REQ-024 SHALL, while RST=1, force state=IDLE, prev=1, counters=0, signal_output=0, data_valid=0, frame_err=0, busy=0 and parity_err=0.
REQ-025 SHALL abandon any partial frame on reset with no output pulse; reset overrides all other events in the same cycle.

Configuration
REQ-026 SHALL, when PARITY_CHECK_EN is defined, add output parity_err (1 bit) and a PARITY state that samples one even-parity bit after the data bits.
REQ-027 SHALL, with PARITY_CHECK_EN defined and a parity mismatch, pulse parity_err with data_valid and still load signal_output; a bad stop bit suppresses both pulses.
REQ-028 SHALL, without PARITY_CHECK_EN, have no parity_err port, no PARITY state and the frame timing of REQ-018.

Structure
REQ-029 SHALL take the state enum typedef and the default DATA_W/BIT_CYCLES constants from shared package shift_frame_pkg.
REQ-030 SHALL instantiate one sub-module, bit_timer, which counts BIT_CYCLES and emits the mid-bit sample strobe.

Verification
REQ-031 SHALL cover: LSB-first frame 0x99, BIT_CYCLES=4 -> signal_output=0x99, data_valid at t0+39, frame_err never asserted.
REQ-032 SHALL cover: MSB-first frame carrying bits 1,0,1,0,0,0,0,0 -> signal_output=0xA0.
REQ-033 SHALL cover: serial_in low for 1 cycle only -> busy falls at t0+3, no pulses, signal_output unchanged.
REQ-034 SHALL cover: 0x3C sent with stop bit 0, after a prior good 0x99 -> frame_err pulse, signal_output stays 0x99, no retrigger while the line stays low.
REQ-035 SHALL cover: RST asserted at data bit 4 -> next cycle all outputs 0 and state IDLE; a following 0x55 frame is received correctly.
REQ-036 SHALL cover, with PARITY_CHECK_EN: 0x07 sent with parity bit 0 -> data_valid and parity_err pulse together, signal_output=0x07.
